// File: rtl/ariane_pkg.sv
// Frontend-to-decode record types shared across the core.
package ariane_pkg;

    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [VLEN-1:0] address;
        logic [31:0]     instruction;
        exception_t      ex;
    } fetch_entry_t;

endpackage

// File: rtl/config_pkg.sv
// Core configuration record. The FIFO only passes it through; the empty
// configuration is the default used by standalone instantiations.
package config_pkg;

    typedef struct packed {
        int unsigned xlen;
        int unsigned vlen;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/fetch_entry_fifo.sv
// In-order buffer between the frontend and decode. Stops accepting after a
// faulting entry until the next flush so fetch never runs past a faulting PC.
module fetch_entry_fifo
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  fetch_entry_t             fetch_entry_i,
    input  logic                     fetch_entry_valid_i,
    output logic                     fetch_entry_ready_o,
    output fetch_entry_t             fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]   usage_o,
    output logic                     ex_blocked_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t          mem_q [DEPTH];
    logic [PtrW-1:0]       wptr_q, wptr_n;
    logic [PtrW-1:0]       rptr_q, rptr_n;
    logic [CntW-1:0]       count_q, count_n;
    logic                  ex_block_q, ex_block_n;
    logic                  push, pop;

    // Ready is purely registered: no path from the decode-side ready.
    assign fetch_entry_ready_o = (count_q != CntW'(DEPTH)) && !ex_block_q;
    assign fetch_entry_valid_o = (count_q != '0);
    assign fetch_entry_o       = mem_q[rptr_q];
    assign usage_o             = count_q;
    assign ex_blocked_o        = ex_block_q;

    assign push = fetch_entry_valid_i && fetch_entry_ready_o && !flush_i;
    assign pop  = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i;

    always_comb begin
        wptr_n     = wptr_q;
        rptr_n     = rptr_q;
        count_n    = count_q;
        ex_block_n = ex_block_q;
        if (flush_i) begin
            wptr_n     = '0;
            rptr_n     = '0;
            count_n    = '0;
            ex_block_n = 1'b0;
        end else begin
            if (push) begin
                wptr_n = wptr_q + PtrW'(1);
                if (fetch_entry_i.ex.valid) begin
                    ex_block_n = 1'b1;
                end
            end
            if (pop) begin
                rptr_n = rptr_q + PtrW'(1);
            end
            count_n = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ex_block_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_n;
            rptr_q     <= rptr_n;
            count_q    <= count_n;
            ex_block_q <= ex_block_n;
        end
    end

    // Storage carries no reset; only the pointers and count define what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= fetch_entry_i;
        end
    end

endmodule

// File: tb/tb_fetch_entry_fifo.sv
// Directed bench for fetch_entry_fifo with DEPTH=4.
module tb_fetch_entry_fifo;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   flush_i;
    fetch_entry_t           fetch_entry_i;
    logic                   fetch_entry_valid_i;
    logic                   fetch_entry_ready_o;
    fetch_entry_t           fetch_entry_o;
    logic                   fetch_entry_valid_o;
    logic                   fetch_entry_ready_i;
    logic [$clog2(DEPTH):0] usage_o;
    logic                   ex_blocked_o;

    int checks = 0;
    int errors = 0;

    fetch_entry_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .usage_o             (usage_o),
        .ex_blocked_o        (ex_blocked_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic fetch_entry_t mk(input logic [63:0] addr, input logic exv);
        fetch_entry_t e;
        e.address        = addr;
        e.instruction    = addr[31:0] ^ 32'h0000_0013;
        e.ex.cause       = exv ? 64'hC : 64'h0;
        e.ex.tval        = exv ? addr : 64'h0;
        e.ex.valid       = exv;
        return e;
    endfunction

    initial begin
        rst_ni              = 1'b0;
        flush_i             = 1'b0;
        fetch_entry_i       = mk(64'h0, 1'b0);
        fetch_entry_valid_i = 1'b0;
        fetch_entry_ready_i = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        check("rst_valid", 64'(fetch_entry_valid_o), 64'd0);
        check("rst_ready", 64'(fetch_entry_ready_o), 64'd1);
        check("rst_usage", 64'(usage_o), 64'd0);
        check("rst_exblk", 64'(ex_blocked_o), 64'd0);

        // Fill A..D with decode stalled, then drain in order.
        fetch_entry_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_entry_i = mk(64'h1000 + 64'(4 * i), 1'b0);
            step();
            check("fill_usage", 64'(usage_o), 64'(i + 1));
        end
        fetch_entry_valid_i = 1'b0;
        check("full_ready", 64'(fetch_entry_ready_o), 64'd0);
        fetch_entry_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 64'(fetch_entry_valid_o), 64'd1);
            check("drain_addr", fetch_entry_o.address, 64'h1000 + 64'(4 * i));
            step();
        end
        check("drain_valid_end", 64'(fetch_entry_valid_o), 64'd0);
        check("drain_usage_end", 64'(usage_o), 64'd0);

        // Streaming: push and pop every cycle, occupancy pinned at 1.
        fetch_entry_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fetch_entry_i = mk(64'h8000_0000 + 64'(4 * i), 1'b0);
            step();
            check("stream_valid", 64'(fetch_entry_valid_o), 64'd1);
            check("stream_usage", 64'(usage_o), 64'd1);
            check("stream_addr", fetch_entry_o.address, 64'h8000_0000 + 64'(4 * i));
        end
        fetch_entry_valid_i = 1'b0;
        step();
        check("stream_usage_end", 64'(usage_o), 64'd0);

        // Nine single push/pop pairs wrap both pointers twice.
        fetch_entry_ready_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            fetch_entry_i       = mk(64'h2000 + 64'(16 * i), 1'b0);
            fetch_entry_valid_i = 1'b1;
            step();
            fetch_entry_valid_i = 1'b0;
            check("wrap_addr", fetch_entry_o.address, 64'h2000 + 64'(16 * i));
            check("wrap_instr", 64'(fetch_entry_o.instruction), 64'((32'h2000 + 32'(16 * i)) ^ 32'h13));
            fetch_entry_ready_i = 1'b1;
            step();
            fetch_entry_ready_i = 1'b0;
            check("wrap_usage", 64'(usage_o), 64'd0);
        end

        // Exception block: X faults, Y must be refused.
        fetch_entry_i       = mk(64'h3000, 1'b1);
        fetch_entry_valid_i = 1'b1;
        step();
        check("exc_blocked", 64'(ex_blocked_o), 64'd1);
        check("exc_ready", 64'(fetch_entry_ready_o), 64'd0);
        fetch_entry_i = mk(64'h3004, 1'b0);
        step();
        step();
        fetch_entry_valid_i = 1'b0;
        check("exc_usage", 64'(usage_o), 64'd1);
        check("exc_addr", fetch_entry_o.address, 64'h3000);
        check("exc_exvalid", 64'(fetch_entry_o.ex.valid), 64'd1);
        check("exc_cause", fetch_entry_o.ex.cause, 64'hC);
        check("exc_tval", fetch_entry_o.ex.tval, 64'h3000);
        fetch_entry_ready_i = 1'b1;
        step();
        fetch_entry_ready_i = 1'b0;
        check("exc_drained", 64'(usage_o), 64'd0);
        check("exc_still_blocked", 64'(ex_blocked_o), 64'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("exc_flush_ready", 64'(fetch_entry_ready_o), 64'd1);
        check("exc_flush_blk", 64'(ex_blocked_o), 64'd0);

        // Flush while full with push and pop both offered.
        fetch_entry_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_entry_i = mk(64'h4000 + 64'(4 * i), 1'b0);
            step();
        end
        check("fl_full_usage", 64'(usage_o), 64'd4);
        fetch_entry_i       = mk(64'h4DDD, 1'b0);
        fetch_entry_ready_i = 1'b1;
        flush_i             = 1'b1;
        step();
        flush_i             = 1'b0;
        fetch_entry_valid_i = 1'b0;
        fetch_entry_ready_i = 1'b0;
        check("fl_usage", 64'(usage_o), 64'd0);
        check("fl_valid", 64'(fetch_entry_valid_o), 64'd0);
        check("fl_ready", 64'(fetch_entry_ready_o), 64'd1);
        fetch_entry_i       = mk(64'h4100, 1'b0);
        fetch_entry_valid_i = 1'b1;
        step();
        fetch_entry_valid_i = 1'b0;
        check("fl_post_usage", 64'(usage_o), 64'd1);
        check("fl_post_addr", fetch_entry_o.address, 64'h4100);
        fetch_entry_ready_i = 1'b1;
        step();
        fetch_entry_ready_i = 1'b0;

        // Reset mid-traffic with 3 entries held, the last one faulting.
        fetch_entry_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_entry_i = mk(64'h5000 + 64'(4 * i), i == 2);
            step();
        end
        check("rm_usage", 64'(usage_o), 64'd3);
        check("rm_blocked", 64'(ex_blocked_o), 64'd1);
        fetch_entry_ready_i = 1'b1;
        rst_ni              = 1'b0;
        step();
        rst_ni              = 1'b1;
        fetch_entry_valid_i = 1'b0;
        fetch_entry_ready_i = 1'b0;
        check("rm_valid", 64'(fetch_entry_valid_o), 64'd0);
        check("rm_ready", 64'(fetch_entry_ready_o), 64'd1);
        check("rm_usage0", 64'(usage_o), 64'd0);
        check("rm_exblk", 64'(ex_blocked_o), 64'd0);
        fetch_entry_i       = mk(64'h6000, 1'b0);
        fetch_entry_valid_i = 1'b1;
        step();
        fetch_entry_valid_i = 1'b0;
        check("rm_post_valid", 64'(fetch_entry_valid_o), 64'd1);
        check("rm_post_addr", fetch_entry_o.address, 64'h6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
